// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit that holds the HI/LO registers.
// mult/multu/div/divu run for a fixed number of cycles with Busy high.
// mthi/mtlo write HI/LO at the next edge while the unit is idle.
//
// Handshake: this is a pulse-launch interface, not valid/ready.
// - Start is sampled only in IDLE, and only with MDop in mult..divu.
// - Busy is the "not ready" indication: while it is high, Start and every
//   MDop value (including mthi/mtlo) are dropped with no effect.
// - Completion is implicit: HI/LO hold the result in the first cycle
//   that Busy is low again.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        dbg_state
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   count_q;
  logic [2:0]         op_q;
  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic [31:0]        hi_q;
  logic [31:0]        lo_q;

  // Result datapath; works only on the operands latched at launch.
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        signed_div;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] divisor;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        launch;

  // The state bit is the busy flag, so Busy comes straight from a flop.
  assign Busy      = (state_q == RUN);
  assign dbg_state = state_q;
  assign HI        = hi_q;
  assign LO        = lo_q;

  assign launch = Start && (MDop >= OP_MULT) && (MDop <= OP_DIVU);

  // Signed division on magnitudes so that 0x80000000 / -1 wraps
  // back to 0x80000000 without any overflow special case.
  always_comb begin
    prod_s     = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u     = {32'd0, a_q} * {32'd0, b_q};
    signed_div = (op_q == OP_DIV);
    abs_a      = (signed_div && a_q[31]) ? (~a_q + 32'd1) : a_q;
    abs_b      = (signed_div && b_q[31]) ? (~b_q + 32'd1) : b_q;
    // A zero divisor never writes HI/LO; substitute 1 to keep the divider defined.
    divisor    = (abs_b == 32'd0) ? 32'd1 : abs_b;
    q_mag      = abs_a / divisor;
    r_mag      = abs_a % divisor;
    quo        = (signed_div && (a_q[31] ^ b_q[31])) ? (~q_mag + 32'd1) : q_mag;
    rem        = (signed_div && a_q[31]) ? (~r_mag + 32'd1) : r_mag;
  end

  // Control FSM plus HI/LO update; reset wins over launch and completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (launch) begin
            op_q    <= MDop;
            a_q     <= A;
            b_q     <= B;
            count_q <= (MDop <= OP_MULTU) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            state_q <= RUN;
          end else if (MDop == OP_MTHI) begin
            hi_q <= A;
          end else if (MDop == OP_MTLO) begin
            lo_q <= A;
          end
        end
        RUN: begin
          count_q <= count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            state_q <= IDLE;
            case (op_q)
              OP_MULT: begin
                hi_q <= prod_s[63:32];
                lo_q <= prod_s[31:0];
              end
              OP_MULTU: begin
                hi_q <= prod_u[63:32];
                lo_q <= prod_u[31:0];
              end
              OP_DIV, OP_DIVU: begin
                if (b_q != 32'd0) begin
                  hi_q <= rem;
                  lo_q <= quo;
                end
              end
              default: begin
              end
            endcase
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL define parameter MULT_CYCLES, default 5, meaning the number of Busy cycles for mult/multu.
REQ-002 SHALL define parameter DIV_CYCLES, default 10, meaning the number of Busy cycles for div/divu.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  one-cycle pulse from the EX stage that launches a mult/multu/div/divu operation.
REQ-006 SHALL have port MDop  input  3  operation code: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo; 111 is treated as none.
REQ-007 SHALL have port A  input  32  operand rs, already forwarded by the EX stage.
REQ-008 SHALL have port B  input  32  operand rt, already forwarded by the EX stage.
REQ-009 SHALL have port Busy  output  1  high while an operation is in flight; the hazard unit uses it for the stall decision.
REQ-010 SHALL have port HI  output  32  current HI register; muxed into ALUout_M for mfhi.
REQ-011 SHALL have port LO  output  32  current LO register; muxed into ALUout_M for mflo.

Function
REQ-012 SHALL hold internal registers HI, LO, Busy, a count register, a pending-op register and latched operands; the state is IDLE when Busy=0 and RUN when Busy=1.
REQ-013 SHALL, in IDLE, on Start=1 with MDop in {001..100}, latch A, B and MDop, load count with MULT_CYCLES or DIV_CYCLES, and set Busy=1 at the same edge.
REQ-014 SHALL, in RUN, decrement count every cycle; when count reaches 1, at that edge, write the result to HI/LO, clear Busy and return to IDLE.
REQ-015 SHALL therefore keep Busy high for exactly MULT_CYCLES or DIV_CYCLES cycles, starting the cycle after the Start edge.
REQ-016 SHALL keep HI and LO at their old values for the whole of RUN; the new result is visible in the cycle after Busy falls.
REQ-017 SHALL ignore Start and any MDop while Busy=1, including mthi/mtlo: no relaunch, no HI/LO write, latched operands unchanged.
REQ-018 SHALL, in IDLE, on MDop=101 write A to HI, and on MDop=110 write A to LO, at the next edge, regardless of Start and with Busy staying 0.
REQ-019 SHALL ignore Start when it is asserted with MDop in {000,101,110,111}; only REQ-018 applies to those codes.
REQ-020 SHALL compute mult as the signed 64-bit product of A and B, and multu as the unsigned product; HI = bits 63:32, LO = bits 31:0.
REQ-021 SHALL compute div as signed division: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
REQ-022 SHALL compute divu as unsigned division: LO = quotient, HI = remainder.
REQ-023 SHALL, for div with A=0x80000000 and B=0xFFFFFFFF, produce LO=0x80000000 and HI=0x00000000 with no trap.
REQ-024 SHALL, for div/divu with B=0, still run DIV_CYCLES cycles with Busy high and leave HI and LO unchanged at completion.
REQ-025 SHALL make the result depend only on the operands latched at Start; later changes to A and B have no effect.
REQ-026 SHALL drive Busy, HI and LO directly from registers, with no combinational path from the inputs.

Reset
REQ-027 SHALL, when reset=1 at a rising edge, clear HI, LO, Busy, count, latched operands and pending op to 0, and enter IDLE.
REQ-028 SHALL give reset priority over Start and over completion; reset during RUN aborts the operation, and neither HI nor LO is written with its result.
REQ-029 SHALL accept a new Start in the first cycle after reset deasserts.

Verification
REQ-030 SHALL cover: mult A=0xFFFFFFFE (-2), B=3 -> Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu on the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-031 SHALL cover: div A=0xFFFFFFF9 (-7), B=2 -> Busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=2 -> LO=3, HI=1.
REQ-032 SHALL cover: with HI=0x11, LO=0x22, div by B=0 -> Busy high 10 cycles, then HI=0x11, LO=0x22; also div 0x80000000 by 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-033 SHALL cover: during mult, pulse Start with div and issue mthi A=0x55 -> both ignored; the mult result lands after 5 cycles.
REQ-034 SHALL cover: in IDLE, mthi A=0xAAAA5555 and then mtlo A=0x1234 -> HI and LO updated one edge after each, with Busy staying 0.
REQ-035 SHALL cover: reset asserted on the 3rd cycle of a div -> Busy=0, HI=LO=0 the next cycle, and no result write afterwards.
